rr_grant_encoder: RTL

//  Round-robin arbiter front end for the 2-to-4 enable decoder stage.

---
 rtl/rr_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_grant_encoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rr_pkg.sv
// Shared constants, state encoding and width helper for the round-robin grant encoder.
package rr_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } rr_state_e;

  // Width needed to count 0..max_hold.
  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: rotate by ptr, priority-encode, un-rotate.
module rr_pick
  import rr_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   rot;
  logic [SELW-1:0]  off;

  // rot[i] is the request of channel (ptr + i) mod NCH.
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr +: NCH];
  assign any     = |req;

  always_comb begin
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
  end

  assign idx = off + ptr;

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter driving a registered {a,b} select and enable, with hold timeout and guard gap.
module rr_grant_encoder
  import rr_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int GUARD    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           done,
  output logic           a,
  output logic           b,
  output logic           en,
  output logic           tout
);

  localparam int              HW_RAW     = hold_w(MAX_HOLD);
  localparam int              HW         = (HW_RAW < 1) ? 1 : HW_RAW;
  localparam logic [HW-1:0]   HOLD_LAST  = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0]   HOLD_SAT   = '1;
  localparam logic [2:0]      GUARD_LAST = 3'(GUARD - 1);

  rr_state_e       state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [2:0]      guard_q, guard_d;
  logic            en_q, en_d;
  logic            tout_q, tout_d;

  logic            pick_any;
  logic [SELW-1:0] pick_idx;
  logic            req_cur;
  logic            timeout_hit;
  logic            release_now;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign req_cur     = req[sel_q];
  assign timeout_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign release_now = done || !req_cur || timeout_hit;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    guard_d = guard_q;
    en_d    = en_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          en_d    = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          en_d    = 1'b0;
          ptr_d   = sel_q + SELW'(1);
          hold_d  = '0;
          guard_d = '0;
          // Timeout is flagged only when neither done nor a dropped request explains the release.
          tout_d  = timeout_hit && !done && req_cur;
          state_d = GAP;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP: begin
        if (guard_q == GUARD_LAST) begin
          guard_d = '0;
          state_d = IDLE;
        end else begin
          guard_d = guard_q + 3'd1;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      guard_q <= '0;
      en_q    <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      guard_q <= guard_d;
      en_q    <= en_d;
      tout_q  <= tout_d;
    end
  end

  assign a    = sel_q[1];
  assign b    = sel_q[0];
  assign en   = en_q;
  assign tout = tout_q;

  // The select may only move on an edge where the enable was low beforehand.
  a_sel_frozen: assert property (@(posedge clk) disable iff (!rst_n)
    !$stable(sel_q) |-> !$past(en_q));

  a_tout_drops_en: assert property (@(posedge clk) disable iff (!rst_n)
    tout_q |-> (!en_q && $past(en_q)));

endmodule
